// File: rtl/multi_channel_acc_if.sv
// rtl/multi_channel_acc_if.sv - sample-in / result-out stream bundle of the multi-channel accumulator
interface multi_channel_acc_if #(
    parameter int DataWidth  = 32,
    parameter int AccWidth   = 40,
    parameter int ChanWidth  = 2,
    parameter int CountWidth = 4
);
    logic                  DataInValid;
    logic                  DataInRdy;
    logic [DataWidth-1:0]  DataIn;
    logic [ChanWidth-1:0]  ChanIn;
    logic [CountWidth-1:0] AccumulateCount;
    logic                  DataOutValid;
    logic                  DataOutRdy;
    logic [AccWidth-1:0]   DataOut;
    logic [ChanWidth-1:0]  ChanOut;
    logic                  Overflow;

    modport master (
        output DataInValid, DataIn, ChanIn, AccumulateCount, DataOutRdy,
        input  DataInRdy, DataOutValid, DataOut, ChanOut, Overflow
    );

    modport slave (
        input  DataInValid, DataIn, ChanIn, AccumulateCount, DataOutRdy,
        output DataInRdy, DataOutValid, DataOut, ChanOut, Overflow
    );
endinterface

// File: rtl/multi_channel_acc.sv
// rtl/multi_channel_acc.sv - per-channel group accumulator with saturate/wrap and FWFT result FIFO
module multi_channel_acc #(
    parameter int DataWidth    = 32,
    parameter int AccWidth     = 40,
    parameter int Channels     = 4,
    parameter int ChanWidth    = 2,
    parameter int CountWidth   = 4,
    parameter int OutFifoDepth = 4,
    parameter int Saturate     = 1
) (
    input logic                clk,
    input logic                aclr,
    multi_channel_acc_if.slave bus
);
    // State is sized for every encodable id; ids >= Channels never write it.
    localparam int Slots      = 1 << ChanWidth;
    localparam int PtrWidth   = $clog2(OutFifoDepth);
    localparam int EntryWidth = AccWidth + ChanWidth + 1;
    localparam logic [AccWidth-1:0] AccMax = {1'b0, {(AccWidth-1){1'b1}}};
    localparam logic [AccWidth-1:0] AccMin = {1'b1, {(AccWidth-1){1'b0}}};

    logic [AccWidth-1:0]   acc_q  [Slots];
    logic [AccWidth-1:0]   acc_d  [Slots];
    logic [CountWidth-1:0] cnt_q  [Slots];
    logic [CountWidth-1:0] cnt_d  [Slots];
    logic [CountWidth-1:0] len_q  [Slots];
    logic [CountWidth-1:0] len_d  [Slots];
    logic                  ovf_q  [Slots];
    logic                  ovf_d  [Slots];
    logic [EntryWidth-1:0] fifo_q [OutFifoDepth];
    logic [EntryWidth-1:0] fifo_d [OutFifoDepth];
    logic [PtrWidth:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrWidth:0]     rd_ptr_q, rd_ptr_d;

    logic                  fifo_empty, fifo_full, accept, pop;
    logic                  chan_ok, first, last, step_ovf, grp_ovf;
    logic [CountWidth-1:0] grp_len, cnt_next;
    logic [AccWidth-1:0]   sample_ext, base, result;
    logic [AccWidth:0]     sum_wide;
    logic [EntryWidth-1:0] head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrWidth] != rd_ptr_q[PtrWidth]) &&
                        (wr_ptr_q[PtrWidth-1:0] == rd_ptr_q[PtrWidth-1:0]);
    assign accept     = bus.DataInValid && bus.DataInRdy;
    assign pop        = !fifo_empty && bus.DataOutRdy;
    assign head       = fifo_empty ? '0 : fifo_q[rd_ptr_q[PtrWidth-1:0]];

    assign bus.DataInRdy    = aclr && !fifo_full;
    assign bus.DataOutValid = !fifo_empty;
    assign bus.DataOut      = head[AccWidth-1:0];
    assign bus.ChanOut      = head[AccWidth +: ChanWidth];
    assign bus.Overflow     = head[EntryWidth-1];

    always_comb begin
        chan_ok    = 32'(bus.ChanIn) < Channels;
        first      = (cnt_q[bus.ChanIn] == '0);
        grp_len    = first ? ((bus.AccumulateCount == '0) ? CountWidth'(1) : bus.AccumulateCount)
                           : len_q[bus.ChanIn];
        cnt_next   = cnt_q[bus.ChanIn] + CountWidth'(1);
        last       = (cnt_next == grp_len);
        sample_ext = AccWidth'(signed'(bus.DataIn));
        base       = first ? '0 : acc_q[bus.ChanIn];
        // One guard bit exposes signed overflow as a mismatch of the top two bits.
        sum_wide   = {base[AccWidth-1], base} + {sample_ext[AccWidth-1], sample_ext};
        step_ovf   = (sum_wide[AccWidth] != sum_wide[AccWidth-1]);
        if (step_ovf && (Saturate != 0)) begin
            result = sum_wide[AccWidth] ? AccMin : AccMax;
        end else begin
            result = sum_wide[AccWidth-1:0];
        end
        grp_ovf = step_ovf || (!first && ovf_q[bus.ChanIn]);

        acc_d    = acc_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept && chan_ok) begin
            acc_d[bus.ChanIn] = result;
            ovf_d[bus.ChanIn] = grp_ovf;
            if (first) begin
                len_d[bus.ChanIn] = grp_len;
            end
            if (last) begin
                cnt_d[bus.ChanIn]                = '0;
                fifo_d[wr_ptr_q[PtrWidth-1:0]]   = {grp_ovf, bus.ChanIn, result};
                wr_ptr_d                         = wr_ptr_q + (PtrWidth+1)'(1);
            end else begin
                cnt_d[bus.ChanIn] = cnt_next;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (PtrWidth+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!aclr) begin
            for (int i = 0; i < Slots; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
                len_q[i] <= '0;
                ovf_q[i] <= 1'b0;
            end
            for (int i = 0; i < OutFifoDepth; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            ovf_q    <= ovf_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

// File: doc/multi_channel_acc.md
MULTI_CHANNEL_ACC -- requirements
Module: multi_channel_acc

Interface
REQ-001 Parameter DataWidth, default 32, signed two's-complement input sample width.
REQ-002 Parameter AccWidth, default 40, accumulator and result width; AccWidth >= DataWidth.
REQ-003 Parameter Channels, default 4, number of independent accumulation channels.
REQ-004 Parameter ChanWidth, default 2, channel-id width; 2^ChanWidth >= Channels.
REQ-005 Parameter CountWidth, default 4, width of the runtime group-length input.
REQ-006 Parameter OutFifoDepth, default 4, result FIFO depth, power of two, >= 2.
REQ-007 Parameter Saturate, default 1: 1 = saturating add, 0 = wrapping add.
REQ-008 clk  input  1  single clock; all state updates on its rising edge.
REQ-009 aclr  input  1  reset; synchronous, active-low.
REQ-010 DataInValid  input  1  producer has a sample on DataIn/ChanIn.
REQ-011 DataInRdy  output  1  block can accept a sample this cycle.
REQ-012 DataIn  input  DataWidth  signed sample.
REQ-013 ChanIn  input  ChanWidth  target channel of the sample.
REQ-014 AccumulateCount  input  CountWidth  samples per group; 0 means 1.
REQ-015 DataOutValid  output  1  result at FIFO head is valid.
REQ-016 DataOutRdy  input  1  consumer accepts the head result.
REQ-017 DataOut  output  AccWidth  signed group sum.
REQ-018 ChanOut  output  ChanWidth  channel of the head result.
REQ-019 Overflow  output  1  head result saturated (Saturate=1) or wrapped (Saturate=0) at least once in its group.

Function
REQ-020 Input handshake: sample accepted on a rising edge where DataInValid and DataInRdy are both high.
REQ-021 DataInRdy SHALL be high iff aclr is high and FIFO occupancy < OutFifoDepth; it SHALL NOT depend combinationally on DataOutRdy.
REQ-022 ChanIn >= Channels with a valid sample: sample accepted and discarded, no state change.
REQ-023 Per channel: accumulator acc[c] (AccWidth), counter cnt[c], latched length len[c].
REQ-024 On an accepted sample with cnt[c]==0, len[c] SHALL latch AccumulateCount (0 -> 1); AccumulateCount changes while cnt[c]!=0 SHALL be ignored for that group.
REQ-025 First sample of a group: acc[c] = sign-extended DataIn; subsequent samples: acc[c] = acc[c] + sign-extended DataIn.
REQ-026 Saturate=1: sum clamps to max/min signed AccWidth value and the group overflow flag is set; Saturate=0: sum wraps modulo 2^AccWidth and signed overflow sets the flag.
REQ-027 Overflow flag SHALL clear at the start of each group.
REQ-028 When the accepted sample is the len[c]-th of the group, the final sum, channel and flag SHALL be pushed into the FIFO on the same edge, cnt[c] reset to 0.
REQ-029 Latency: last sample accepted on edge k with FIFO empty -> DataOutValid high and DataOut valid after edge k (one cycle).
REQ-030 FIFO is first-word-fall-through; DataOutValid = FIFO non-empty; pop on DataOutValid and DataOutRdy.
REQ-031 Simultaneous push and pop: occupancy unchanged, order preserved.
REQ-032 Results SHALL leave in completion order across channels.
REQ-033 DataOut/ChanOut/Overflow SHALL hold stable while DataOutValid is high and DataOutRdy is low.
REQ-034 Channels accumulate independently; interleaved channel ids SHALL not affect other channels' sums.

Reset
REQ-035 aclr low at a rising edge SHALL clear all acc, cnt, len, flags and FIFO pointers.
REQ-036 After reset: DataOutValid=0, DataOut=0, ChanOut=0, Overflow=0; DataInRdy=0 while aclr low.
REQ-037 Reset mid-group SHALL discard partial sums and queued results; no result emitted for them.
REQ-038 First cycle with aclr high: DataInRdy=1.

Verification
REQ-039 Ch0, AccumulateCount=4, samples 401,400,401,400 back-to-back -> single result DataOut=1602, ChanOut=0, Overflow=0, valid one cycle after 4th accept.
REQ-040 Count=2, interleaved (ch0,10),(ch1,-5),(ch0,20),(ch1,-7) -> results (0,30) then (1,-12) in that order.
REQ-041 Count=1, DataOutRdy=0, five samples 1..5 -> DataInRdy low after 4 accepts, 5th held; DataOutRdy=1 -> outputs 1,2,3,4,5 then DataInRdy high.
REQ-042 DataWidth=AccWidth=8, count=2, 100+100: Saturate=1 -> 127, Overflow=1; Saturate=0 -> -56, Overflow=1.
REQ-043 Ch2 count=4, two samples, aclr low one cycle, then four samples of 1 -> only result DataOut=4, ChanOut=2.
REQ-044 Ch0 group started with AccumulateCount=3, changed to 2 after first sample, samples 1,2,3 -> result 6 after third sample only.
